// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and config decode for the convolution sequencer.
// Window-control bundle carried through the MAC-latency delay line.
package conv_pkg;

    localparam int FMAP_W   = 64;
    localparam int OFM_W    = FMAP_W - 3;
    localparam int COLP_MAX = FMAP_W / 2 - 1;
    localparam int MAC_LAT  = 3;
    localparam int KNL_K    = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LD_KNL  = 3'd1,
        ST_LD_DATA = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0]  win_vld;
        logic [11:0] addr;
        logic        clr;
        logic        wr;
    } psum_ctl_t;

    // 0 -> 8, 1 -> 16, 2 -> 24, anything larger saturates at 32.
    function automatic logic [5:0] cfg_to_count(input logic [2:0] cfg);
        if (cfg >= 3'd3) begin
            return 6'd32;
        end
        return {1'b0, cfg[1:0] + 2'd1, 3'b000};
    endfunction

endpackage

// File: rtl/conv_vld_pipe.sv
// Fixed-depth delay line that lines the window controls up with the MAC array output.
module conv_vld_pipe #(
    parameter int DEPTH = 3,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: steps kernel/channel/row/column-pair counters, marks load cycles
// and produces psum clear/accumulate/write strobes delayed by the MAC latency.
module conv_seq_ctrl #(
    parameter int MAC_LAT = conv_pkg::MAC_LAT,
    parameter int FMAP_W  = conv_pkg::FMAP_W,
    parameter int KNL_K   = conv_pkg::KNL_K
) (
    input  logic        clk,
    input  logic        in_rst,
    input  logic        in_start_conv,
    input  logic [2:0]  in_cfg_ci,
    input  logic [2:0]  in_cfg_co,
    output logic        out_ld_knl,
    output logic        out_knl_word,
    output logic        out_ld_data,
    output logic [5:0]  out_row,
    output logic [4:0]  out_colp,
    output logic [4:0]  out_chnl,
    output logic [4:0]  out_knl,
    output logic [1:0]  out_win_vld,
    output logic [11:0] out_psum_addr,
    output logic        out_psum_clr,
    output logic        out_writeCtl,
    output logic        out_end_conv,
    output logic        out_busy,
    output logic [2:0]  dbg_state
);

    import conv_pkg::*;

    localparam int OFM_ROWS  = FMAP_W - 3;
    localparam int COLP_LAST = FMAP_W / 2 - 1;
    localparam int KNL_WORDS = KNL_K * KNL_K / 8;

    state_t     state, state_n;
    logic [5:0] nci, nco, nci_n, nco_n;
    logic       word, word_n;
    logic [5:0] row, row_n;
    logic [4:0] colp, colp_n, chnl, chnl_n, knl, knl_n;
    logic [7:0] drain_cnt, drain_n;
    logic       last_col, last_row, last_chnl, last_knl;
    psum_ctl_t  ctl_in, ctl_out;

    assign last_col  = (colp == 5'(COLP_LAST));
    assign last_row  = (row == 6'(OFM_ROWS - 1));
    assign last_chnl = ({1'b0, chnl} == nci - 6'd1);
    assign last_knl  = ({1'b0, knl} == nco - 6'd1);

    always_comb begin
        state_n = state;
        nci_n   = nci;
        nco_n   = nco;
        word_n  = word;
        row_n   = row;
        colp_n  = colp;
        chnl_n  = chnl;
        knl_n   = knl;
        drain_n = drain_cnt;
        case (state)
            ST_IDLE: begin
                if (in_start_conv) begin
                    state_n = ST_LD_KNL;
                    nci_n   = cfg_to_count(in_cfg_ci);
                    nco_n   = cfg_to_count(in_cfg_co);
                    word_n  = 1'b0;
                    row_n   = '0;
                    colp_n  = '0;
                    chnl_n  = '0;
                    knl_n   = '0;
                    drain_n = '0;
                end
            end
            ST_LD_KNL: begin
                if (word == 1'(KNL_WORDS - 1)) begin
                    state_n = ST_LD_DATA;
                    word_n  = 1'b0;
                    row_n   = '0;
                    colp_n  = '0;
                end else begin
                    word_n = word + 1'b1;
                end
            end
            ST_LD_DATA: begin
                if (!last_col) begin
                    colp_n = colp + 5'd1;
                end else if (!last_row) begin
                    colp_n = '0;
                    row_n  = row + 6'd1;
                end else begin
                    // Finished one channel's full ifmap sweep.
                    colp_n = '0;
                    row_n  = '0;
                    if (!last_chnl) begin
                        chnl_n  = chnl + 5'd1;
                        state_n = ST_LD_KNL;
                    end else if (!last_knl) begin
                        chnl_n  = '0;
                        knl_n   = knl + 5'd1;
                        state_n = ST_LD_KNL;
                    end else begin
                        chnl_n  = '0;
                        knl_n   = '0;
                        state_n = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 8'(MAC_LAT - 1)) begin
                    drain_n = '0;
                    state_n = ST_DONE;
                end else begin
                    drain_n = drain_cnt + 8'd1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Lane 1 covers window start 2c-2, lane 0 covers 2c-3; the address names the lowest valid start.
    always_comb begin
        ctl_in = '0;
        if (state == ST_LD_DATA && colp != 5'd0) begin
            ctl_in.win_vld = (colp == 5'd1) ? 2'b10 : 2'b11;
            ctl_in.addr    = 12'(row) * 12'(OFM_ROWS)
                           + ((colp == 5'd1) ? 12'd0 : 12'({colp, 1'b0}) - 12'd3);
            ctl_in.clr     = (chnl == 5'd0);
            ctl_in.wr      = last_chnl;
        end
    end

    always_ff @(posedge clk) begin
        if (in_rst) begin
            state        <= ST_IDLE;
            nci          <= '0;
            nco          <= '0;
            word         <= 1'b0;
            row          <= '0;
            colp         <= '0;
            chnl         <= '0;
            knl          <= '0;
            drain_cnt    <= '0;
            out_ld_knl   <= 1'b0;
            out_knl_word <= 1'b0;
            out_ld_data  <= 1'b0;
            out_end_conv <= 1'b0;
            out_busy     <= 1'b0;
        end else begin
            state        <= state_n;
            nci          <= nci_n;
            nco          <= nco_n;
            word         <= word_n;
            row          <= row_n;
            colp         <= colp_n;
            chnl         <= chnl_n;
            knl          <= knl_n;
            drain_cnt    <= drain_n;
            out_ld_knl   <= (state_n == ST_LD_KNL);
            out_knl_word <= (state_n == ST_LD_KNL) && word_n;
            out_ld_data  <= (state_n == ST_LD_DATA);
            out_end_conv <= (state_n == ST_DONE);
            out_busy     <= (state_n != ST_IDLE);
        end
    end

    conv_vld_pipe #(
        .DEPTH (MAC_LAT),
        .W     ($bits(psum_ctl_t))
    ) u_vld_pipe (
        .clk  (clk),
        .rst  (in_rst),
        .din  (ctl_in),
        .dout (ctl_out)
    );

    assign out_row       = row;
    assign out_colp      = colp;
    assign out_chnl      = chnl;
    assign out_knl       = knl;
    assign out_win_vld   = ctl_out.win_vld;
    assign out_psum_addr = ctl_out.addr;
    assign out_psum_clr  = ctl_out.clr;
    assign out_writeCtl  = ctl_out.wr;
    assign dbg_state     = state;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl on a reduced 16x16 ifmap so full multi-kernel runs stay short.
module tb_conv_seq_ctrl;

    localparam int MAC_LAT = 3;
    localparam int FMAP_W  = 16;
    localparam int OFM_W   = FMAP_W - 3;
    localparam int COLPS   = FMAP_W / 2;
    localparam int PER_CH  = 2 + OFM_W * COLPS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        in_rst = 1'b1;
    logic        in_start_conv = 1'b0;
    logic [2:0]  in_cfg_ci = 3'd0;
    logic [2:0]  in_cfg_co = 3'd0;
    logic        out_ld_knl, out_knl_word, out_ld_data;
    logic [5:0]  out_row;
    logic [4:0]  out_colp, out_chnl, out_knl;
    logic [1:0]  out_win_vld;
    logic [11:0] out_psum_addr;
    logic        out_psum_clr, out_writeCtl, out_end_conv, out_busy;
    logic [2:0]  dbg_state;

    conv_seq_ctrl #(
        .MAC_LAT (MAC_LAT),
        .FMAP_W  (FMAP_W),
        .KNL_K   (4)
    ) dut (
        .clk           (clk),
        .in_rst        (in_rst),
        .in_start_conv (in_start_conv),
        .in_cfg_ci     (in_cfg_ci),
        .in_cfg_co     (in_cfg_co),
        .out_ld_knl    (out_ld_knl),
        .out_knl_word  (out_knl_word),
        .out_ld_data   (out_ld_data),
        .out_row       (out_row),
        .out_colp      (out_colp),
        .out_chnl      (out_chnl),
        .out_knl       (out_knl),
        .out_win_vld   (out_win_vld),
        .out_psum_addr (out_psum_addr),
        .out_psum_clr  (out_psum_clr),
        .out_writeCtl  (out_writeCtl),
        .out_end_conv  (out_end_conv),
        .out_busy      (out_busy),
        .dbg_state     (dbg_state)
    );

    logic [41:0] all_outs;
    assign all_outs = {out_ld_knl, out_knl_word, out_ld_data, out_row, out_colp, out_chnl,
                       out_knl, out_win_vld, out_psum_addr, out_psum_clr, out_writeCtl,
                       out_end_conv, out_busy};

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int run_nci = 0, run_nco = 0, run_start = 0, next_nci = 0, next_nco = 0;
    int n_knl = 0, n_data = 0, n_wr = 0, ends_total = 0, end_cyc = 0, first_busy = 0;
    bit busy_q = 1'b0, relaunch_pend = 1'b0, knl_phase = 1'b0, mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int cfg_count(input int cfg);
        return (cfg >= 3) ? 32 : 8 * (cfg + 1);
    endfunction

    // Expected psum-port stream for one run: one entry per cycle with a valid window.
    task automatic push_run(input int nci, input int nco);
        for (int k = 0; k < nco; k++) begin
            for (int c = 0; c < nci; c++) begin
                for (int r = 0; r < OFM_W; r++) begin
                    for (int p = 1; p < COLPS; p++) begin
                        logic [1:0] v;
                        int start_w;
                        v       = (p >= 2) ? 2'b11 : 2'b10;
                        start_w = v[0] ? (2 * p - 3) : (2 * p - 2);
                        exp_q.push_back({v, 12'(r * OFM_W + start_w), c == 0, c == nci - 1});
                    end
                end
            end
        end
    endtask

    // One cycle: advance to the falling edge and run the monitor.
    task automatic tick();
        logic [15:0] got;
        logic [20:0] exp_pos;
        int pair;
        @(negedge clk);
        cyc++;
        if (mon_en) begin
            if (out_busy && !busy_q) begin
                if (relaunch_pend) check("relaunch_gap", 64'(cyc - end_cyc), 64'd2);
                relaunch_pend = 1'b0;
                run_nci    = next_nci;
                run_nco    = next_nco;
                run_start  = cyc - 1;
                first_busy = cyc;
                n_knl = 0; n_data = 0; n_wr = 0; knl_phase = 1'b0;
            end
            busy_q = out_busy;
            if (out_ld_knl) begin
                check("knl_word", 64'(out_knl_word), 64'(knl_phase));
                knl_phase = ~knl_phase;
                n_knl++;
            end
            if (out_ld_data) begin
                pair    = n_data / (COLPS * OFM_W);
                exp_pos = {5'(pair / run_nci), 5'(pair % run_nci),
                           6'((n_data / COLPS) % OFM_W), 5'(n_data % COLPS)};
                check("ld_pos", 64'({out_knl, out_chnl, out_row, out_colp}), 64'(exp_pos));
                n_data++;
            end
            if (out_win_vld != 2'b00) begin
                got = {out_win_vld, out_psum_addr, out_psum_clr, out_writeCtl};
                if (exp_q.size() == 0) check("psum_unexp", 64'(got), 64'd0);
                else check("psum", 64'(got), 64'(exp_q.pop_front()));
                if (out_writeCtl) n_wr++;
            end else if (out_psum_clr || out_writeCtl) begin
                check("psum_idle", 64'({out_psum_clr, out_writeCtl}), 64'd0);
            end
            if (out_end_conv) begin
                check("end_latency", 64'(cyc - run_start),
                      64'(run_nci * run_nco * PER_CH + MAC_LAT + 1));
                check("n_ld_knl", 64'(n_knl), 64'(2 * run_nci * run_nco));
                check("n_ld_data", 64'(n_data), 64'(run_nci * run_nco * OFM_W * COLPS));
                check("n_writes", 64'(n_wr), 64'(run_nco * OFM_W * (COLPS - 1)));
                end_cyc = cyc;
                ends_total++;
                if (in_start_conv) relaunch_pend = 1'b1;
            end
        end
    endtask

    task automatic wait_end(input int budget);
        int e0;
        int n;
        e0 = ends_total;
        n  = 0;
        while (ends_total == e0 && n < budget) begin
            tick();
            n++;
        end
        check("end_conv_seen", 64'(ends_total - e0), 64'd1);
    endtask

    // ---------------- driver ----------------
    initial begin
        int drv_start;
        int found;
        int n;

        repeat (3) tick();
        check("reset_outs", 64'(all_outs), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        in_rst = 1'b0;
        tick();
        check("idle_outs", 64'(all_outs), 64'd0);
        mon_en = 1'b1;

        // Run A: 8 channels x 8 kernels, single start pulse.
        next_nci = cfg_count(0);
        next_nco = cfg_count(0);
        push_run(next_nci, next_nco);
        in_cfg_ci = 3'd0;
        in_cfg_co = 3'd0;
        in_start_conv = 1'b1;
        drv_start = cyc;
        tick();
        in_start_conv = 1'b0;
        check("start_to_ld_knl", 64'(first_busy - drv_start), 64'd1);
        check("ld_knl_c1", 64'({out_ld_knl, out_knl_word, out_ld_data, out_busy}), 64'b1001);
        tick();
        check("ld_knl_c2", 64'({out_ld_knl, out_knl_word, out_ld_data, out_busy}), 64'b1101);
        tick();
        check("first_ld_data", 64'({out_ld_knl, out_ld_data, out_row, out_colp}), 64'({2'b01, 11'd0}));
        wait_end(8 * 8 * PER_CH + 50);
        tick();
        check("post_done", 64'({out_end_conv, out_busy}), 64'd0);
        check("sb_empty_a", 64'(exp_q.size()), 64'd0);

        // Run B: 16 channels; cfg changes mid-run must be ignored; start held for relaunch.
        next_nci = cfg_count(1);
        next_nco = cfg_count(0);
        push_run(next_nci, next_nco);
        in_cfg_ci = 3'd1;
        in_cfg_co = 3'd0;
        in_start_conv = 1'b1;
        tick();
        repeat ($urandom_range(200, 900)) tick();
        in_cfg_ci = 3'd3;
        in_cfg_co = 3'($urandom_range(1, 7));
        repeat (1000) tick();
        in_cfg_ci = 3'd7;
        in_cfg_co = 3'd0;
        next_nci = cfg_count(7);
        next_nco = cfg_count(0);
        push_run(next_nci, next_nco);
        wait_end(16 * 8 * PER_CH + 50);

        // Run C: relaunched from DONE with cfg 7 (32 channels).
        tick();
        tick();
        check("relaunch_ld_knl", 64'({out_ld_knl, out_knl_word, out_busy}), 64'b101);
        in_start_conv = 1'b0;
        wait_end(32 * 8 * PER_CH + 50);
        tick();
        check("post_done_c", 64'({out_end_conv, out_busy}), 64'd0);
        check("sb_empty_c", 64'(exp_q.size()), 64'd0);

        // Run D: abort with reset mid-run, then restart.
        mon_en = 1'b0;
        in_cfg_ci = 3'd1;
        in_cfg_co = 3'd0;
        in_start_conv = 1'b1;
        tick();
        in_start_conv = 1'b0;
        found = 0;
        n = 0;
        while (found == 0 && n < 5000) begin
            tick();
            n++;
            if (out_ld_data && out_chnl == 5'd3 && out_row == 6'd5) found = 1;
        end
        check("abort_reach", 64'(found), 64'd1);
        in_rst = 1'b1;
        tick();
        check("abort_outs", 64'(all_outs), 64'd0);
        check("abort_state", 64'(dbg_state), 64'd0);
        in_rst = 1'b0;
        tick();
        check("abort_quiet", 64'(all_outs), 64'd0);
        in_start_conv = 1'b1;
        tick();
        in_start_conv = 1'b0;
        check("restart_knl", 64'({out_ld_knl, out_knl_word, out_ld_data}), 64'b100);
        check("restart_pos", 64'({out_knl, out_chnl, out_row, out_colp}), 64'd0);
        repeat (4) tick();
        in_rst = 1'b1;
        tick();
        in_rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
